// File: rtl/accel_addr_gen.sv
// accel_addr_gen: address generation unit for the accelerator memory-request path.
// A start pulse in IDLE latches the base address, length and access pattern
// (sequential, 2D tile walk or circular buffer). The unit then emits `length`
// addresses over a valid/ready handshake and pulses done after the last one
// is accepted.
// Optional feature macro: AGU_STALL_CNT_EN adds the stall_cycles port. This
// port counts the cycles in which an address was offered but not accepted.

package accel_pkg;
    parameter int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        SEQUENTIAL = 2'd0,
        SLIDING_2D = 2'd1,
        CIRCULAR   = 2'd2
    } access_pattern_e;
endpackage

module accel_addr_gen
    import accel_pkg::*;
#(
    parameter int AW = accel_pkg::ADDR_WIDTH,
    parameter int LW = 16
`ifdef AGU_STALL_CNT_EN
    ,
    parameter int STALL_CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  access_pattern_e pattern,
    input  logic [AW-1:0]   base_addr,
    input  logic [LW-1:0]   length,
    input  logic [LW-1:0]   tile_w,
    input  logic [AW-1:0]   row_stride,
    input  logic [LW-1:0]   circ_size,
    input  logic [LW-1:0]   circ_offset,
    output logic [AW-1:0]   addr,
    output logic            addr_valid,
    input  logic            addr_ready,
    output logic            done,
    output logic            busy
`ifdef AGU_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_next;

    // Sequence context captured at start
    access_pattern_e r_pat;
    logic [AW-1:0]   r_base;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_tile_w;
    logic [AW-1:0]   r_stride;
    logic [LW-1:0]   r_csize;

    // Walk state
    logic [LW-1:0]   r_idx;
    logic [LW-1:0]   r_col;
    logic [AW-1:0]   r_row_base;
    logic [LW-1:0]   r_ptr;
    logic [AW-1:0]   r_addr;

    logic            r_valid;
    logic            r_done;
    logic            r_busy;

    logic            w_start_ok;
    logic            w_hs;
    logic            w_last;
    access_pattern_e w_pat;
    logic [LW-1:0]   w_tile_eff;
    logic [LW-1:0]   w_csize_eff;
    logic [LW-1:0]   w_ptr0;

    assign w_start_ok  = start && (r_state == S_IDLE);
    assign w_hs        = r_valid && addr_ready;
    assign w_last      = (r_idx == r_len - LW'(1));

    // Unknown pattern encodings fall back to a sequential walk.
    assign w_pat       = (pattern == SLIDING_2D || pattern == CIRCULAR) ? pattern : SEQUENTIAL;
    assign w_tile_eff  = (tile_w == '0) ? LW'(1) : tile_w;
    assign w_csize_eff = (circ_size == '0) ? LW'(1) : circ_size;
    // A single subtraction is enough because callers keep circ_offset below twice the buffer depth.
    assign w_ptr0      = (circ_offset >= w_csize_eff) ? (circ_offset - w_csize_eff) : circ_offset;

    // Next-state decode for the IDLE -> RUN/DONE -> IDLE sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_hs && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus registered status flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            r_busy  <= (w_next != S_IDLE);
        end
    end

    // Latch the sequence context on start and advance the walk on each non-final handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat      <= SEQUENTIAL;
            r_base     <= '0;
            r_len      <= '0;
            r_tile_w   <= '0;
            r_stride   <= '0;
            r_csize    <= '0;
            r_idx      <= '0;
            r_col      <= '0;
            r_row_base <= '0;
            r_ptr      <= '0;
            r_addr     <= '0;
        end else if (w_start_ok) begin
            r_pat      <= w_pat;
            r_base     <= base_addr;
            r_len      <= length;
            r_tile_w   <= w_tile_eff;
            r_stride   <= row_stride;
            r_csize    <= w_csize_eff;
            r_idx      <= '0;
            r_col      <= '0;
            r_row_base <= base_addr;
            r_ptr      <= w_ptr0;
            r_addr     <= (w_pat == CIRCULAR) ? (base_addr + AW'(w_ptr0)) : base_addr;
        end else if (w_hs && !w_last) begin
            r_idx <= r_idx + LW'(1);
            case (r_pat)
                SLIDING_2D: begin
                    // End of a tile row: jump to the next row base instead of multiplying.
                    if (r_col == r_tile_w - LW'(1)) begin
                        r_col      <= '0;
                        r_row_base <= r_row_base + r_stride;
                        r_addr     <= r_row_base + r_stride;
                    end else begin
                        r_col  <= r_col + LW'(1);
                        r_addr <= r_addr + AW'(1);
                    end
                end
                CIRCULAR: begin
                    if (r_ptr == r_csize - LW'(1)) begin
                        r_ptr  <= '0;
                        r_addr <= r_base;
                    end else begin
                        r_ptr  <= r_ptr + LW'(1);
                        r_addr <= r_addr + AW'(1);
                    end
                end
                default: r_addr <= r_addr + AW'(1);
            endcase
        end
    end

`ifdef AGU_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall;

    // Count offered-but-refused cycles, saturating, restarting on each accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_start_ok) begin
            r_stall <= '0;
        end else if (r_valid && !addr_ready && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall;
`endif

    assign addr       = r_addr;
    assign addr_valid = r_valid;
    assign done       = r_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_accel_addr_gen.sv
// Self-checking bench for accel_addr_gen: directed scenarios followed by
// randomized sequences, checked against an index-based address model.

module tb_accel_addr_gen;
  import accel_pkg::*;

  localparam int AW = 32;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  access_pattern_e pattern = SEQUENTIAL;
  logic [AW-1:0]   base_addr = '0;
  logic [LW-1:0]   length = '0;
  logic [LW-1:0]   tile_w = '0;
  logic [AW-1:0]   row_stride = '0;
  logic [LW-1:0]   circ_size = '0;
  logic [LW-1:0]   circ_offset = '0;
  logic [AW-1:0]   addr;
  logic            addr_valid;
  logic            addr_ready = 1'b0;
  logic            done;
  logic            busy;
`ifdef AGU_STALL_CNT_EN
  logic [31:0]     stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  accel_addr_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pattern     (pattern),
    .base_addr   (base_addr),
    .length      (length),
    .tile_w      (tile_w),
    .row_stride  (row_stride),
    .circ_size   (circ_size),
    .circ_offset (circ_offset),
    .addr        (addr),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .done        (done),
    .busy        (busy)
`ifdef AGU_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  task automatic check(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address of element i, computed directly from the index.
  function automatic logic [AW-1:0] model_addr(input int pat, input logic [AW-1:0] base,
                                                input logic [AW-1:0] stride, input int i,
                                                input int tw, input int cs, input int co);
    int twe, cse, cor;
    twe = (tw == 0) ? 1 : tw;
    cse = (cs == 0) ? 1 : cs;
    cor = (co >= cse) ? co - cse : co;
    case (pat)
      1:       return base + AW'(i / twe) * stride + AW'(i % twe);
      2:       return base + AW'((cor + i) % cse);
      default: return base + AW'(i);
    endcase
  endfunction

  task automatic scramble_inputs();
    pattern     = access_pattern_e'(2'($urandom_range(0, 3)));
    base_addr   = $urandom;
    length      = LW'($urandom);
    tile_w      = LW'($urandom);
    row_stride  = $urandom;
    circ_size   = LW'($urandom);
    circ_offset = LW'($urandom);
  endtask

  // rmode: 0 = ready always high, 1 = random ready, 2 = ready low on cycles 1 and 2.
  task automatic run_seq(input string name, input int pat, input logic [AW-1:0] base,
                         input logic [AW-1:0] stride, input int len, input int tw,
                         input int cs, input int co, input int rmode, input bit poke);
    logic [AW-1:0] exp_q[$];
    int k, cyc, stalls;
    bit rdy;
    for (int i = 0; i < len; i++) exp_q.push_back(model_addr(pat, base, stride, i, tw, cs, co));

    pattern     = access_pattern_e'(2'(pat));
    base_addr   = base;
    length      = LW'(len);
    tile_w      = LW'(tw);
    row_stride  = stride;
    circ_size   = LW'(cs);
    circ_offset = LW'(co);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    k = 0; cyc = 0; stalls = 0;

    if (len == 0) begin
      check({name, ".len0_done"}, done === 1'b1, 64'(done), 64'(1));
      check({name, ".len0_valid"}, addr_valid === 1'b0, 64'(addr_valid), 64'(0));
    end else begin
      while (k < len && cyc < 300) begin
        check($sformatf("%s.valid[%0d]", name, k), addr_valid === 1'b1, 64'(addr_valid), 64'(1));
        check($sformatf("%s.addr[%0d]", name, k), addr === exp_q[k], 64'(addr), 64'(exp_q[k]));
        check($sformatf("%s.busy[%0d]", name, k), busy === 1'b1, 64'(busy), 64'(1));
        check($sformatf("%s.nodone[%0d]", name, k), done === 1'b0, 64'(done), 64'(0));
        if (rmode == 0)      rdy = 1'b1;
        else if (rmode == 2) rdy = !(cyc == 1 || cyc == 2);
        else                 rdy = ($urandom_range(0, 3) != 0);
        if (poke && cyc == 1) begin
          start     = 1'b1;
          length    = '0;
          base_addr = ~base;
        end
        addr_ready = rdy;
        if (rdy) k++;
        else     stalls++;
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
      if (k < len) check({name, ".timeout"}, k === len, 64'(k), 64'(len));
      check({name, ".done"}, done === 1'b1, 64'(done), 64'(1));
      check({name, ".valid_end"}, addr_valid === 1'b0, 64'(addr_valid), 64'(0));
    end
    addr_ready = 1'($urandom);
    @(negedge clk);
    check({name, ".done_pulse"}, done === 1'b0, 64'(done), 64'(0));
    check({name, ".idle_busy"}, busy === 1'b0, 64'(busy), 64'(0));
    check({name, ".idle_valid"}, addr_valid === 1'b0, 64'(addr_valid), 64'(0));
`ifdef AGU_STALL_CNT_EN
    check({name, ".stall"}, stall_cycles === 32'(stalls), 64'(stall_cycles), 64'(stalls));
`endif
  endtask

  initial begin
    int pat, len, tw, cs, cse, co;
    logic [AW-1:0] base, stride;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.addr", addr === '0, 64'(addr), 64'(0));
    check("rst.valid", addr_valid === 1'b0, 64'(addr_valid), 64'(0));
    check("rst.done", done === 1'b0, 64'(done), 64'(0));
    check("rst.busy", busy === 1'b0, 64'(busy), 64'(0));
`ifdef AGU_STALL_CNT_EN
    check("rst.stall", stall_cycles === '0, 64'(stall_cycles), 64'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    run_seq("t1_seq",  0, 32'h100,  32'h0,  4, 0, 0, 0, 0, 1'b0);
    run_seq("t2_2d",   1, 32'h1000, 32'h40, 7, 3, 0, 0, 0, 1'b0);
    run_seq("t3_circ", 2, 32'h200,  32'h0,  6, 0, 4, 2, 0, 1'b0);
    run_seq("t4_bp",   0, 32'h300,  32'h0,  3, 0, 0, 0, 2, 1'b0);
    run_seq("t5_len0", 0, 32'h400,  32'h0,  0, 0, 0, 0, 0, 1'b0);
    run_seq("t5_poke", 0, 32'h480,  32'h0,  5, 0, 0, 0, 0, 1'b1);
    run_seq("t_wrap",  0, 32'hFFFF_FFFE, 32'h0, 4, 0, 0, 0, 0, 1'b0);
    run_seq("t_pat3",  3, 32'h700,  32'h0,  3, 0, 0, 0, 0, 1'b0);
    run_seq("t_c0",    2, 32'h800,  32'h0,  3, 0, 0, 1, 1, 1'b0);
    run_seq("t_cbig",  2, 32'h900,  32'h0,  5, 0, 3, 4, 1, 1'b0);

    // Reset asserted in the middle of a run
    pattern = SEQUENTIAL; base_addr = 32'h500; length = LW'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0; addr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t6.pre_valid", addr_valid === 1'b1, 64'(addr_valid), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("t6.valid", addr_valid === 1'b0, 64'(addr_valid), 64'(0));
    check("t6.done", done === 1'b0, 64'(done), 64'(0));
    check("t6.busy", busy === 1'b0, 64'(busy), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("t6.no_done", done === 1'b0, 64'(done), 64'(0));
    run_seq("t6_after", 0, 32'h10, 32'h0, 1, 0, 0, 0, 0, 1'b0);

    // Randomized sequences
    for (int n = 0; n < 40; n++) begin
      pat    = $urandom_range(0, 3);
      base   = $urandom;
      stride = $urandom;
      len    = $urandom_range(0, 12);
      tw     = $urandom_range(0, 5);
      cs     = $urandom_range(0, 6);
      cse    = (cs == 0) ? 1 : cs;
      co     = $urandom_range(0, 2 * cse - 1);
      run_seq($sformatf("rnd%0d", n), pat, base, stride, len, tw, cs, co, 1,
              ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
